// File: rtl/int_to_float_converter.sv
// rtl/int_to_float_converter.sv - pipelined 32-bit integer to IEEE-754 single converter
module int_to_float_converter #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] operand_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic        inexact_o,
  output logic        valid_o,
  input  logic        ready_i
);

  logic        adv;
  logic        in_sign;
  logic [31:0] in_mag;

  logic        s1_valid;
  logic        s1_sign;
  logic [31:0] s1_mag;

  logic [4:0]  lz;
  logic        mag_zero;

  logic        s2_valid;
  logic        s2_sign;
  logic        s2_zero;
  logic [4:0]  s2_lz;
  logic [30:0] s2_norm;

  logic [7:0]  exp_base;
  logic [7:0]  exp_fin;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [31:0] result_d;
  logic        inexact_d;

  // The whole pipe moves together; it only freezes when a finished result is refused.
  assign adv     = ready_i | ~valid_o;
  assign ready_o = adv;

  assign in_sign = SIGNED & operand_i[31];
  assign in_mag  = in_sign ? (~operand_i + 32'd1) : operand_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= 32'd0;
    end else if (adv) begin
      s1_valid <= valid_i;
      s1_sign  <= in_sign;
      s1_mag   <= in_mag;
    end
  end

  // Leading-zero count: the highest set bit wins because it is visited last.
  always_comb begin
    lz       = 5'd0;
    mag_zero = (s1_mag == 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (s1_mag[i]) lz = 5'(31 - i);
    end
  end

  // The normalized hidden bit is implicit, so only the 31 bits below it are kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_lz    <= 5'd0;
      s2_norm  <= 31'd0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= mag_zero;
      s2_lz    <= lz;
      s2_norm  <= s1_mag[30:0] << lz;
    end
  end

  always_comb begin
    exp_base  = 8'd158 - {3'b000, s2_lz};
    guard     = s2_norm[7];
    sticky    = |s2_norm[6:0];
    round_up  = guard & (sticky | s2_norm[8]);
    // A carry out of the mantissa leaves the low 23 bits at zero and bumps the exponent.
    mant_sum  = {1'b0, s2_norm[30:8]} + {23'd0, round_up};
    exp_fin   = exp_base + {7'd0, mant_sum[23]};
    result_d  = s2_zero ? 32'd0 : {s2_sign, exp_fin, mant_sum[22:0]};
    inexact_d = ~s2_zero & (guard | sticky);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      result_o  <= 32'd0;
      inexact_o <= 1'b0;
    end else if (adv) begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        result_o  <= result_d;
        inexact_o <= inexact_d;
      end
    end
  end

endmodule

// File: tb/tb_int_to_float_converter.sv
// tb/tb_int_to_float_converter.sv - scoreboard bench for int_to_float_converter
module tb_int_to_float_converter;

  logic        clk;
  logic        rst_i;
  logic [31:0] operand_i;
  logic        valid_i;
  logic        ready_i;

  logic        ready_s, valid_s, inexact_s;
  logic [31:0] result_s;
  logic        ready_u, valid_u, inexact_u;
  logic [31:0] result_u;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];

  int_to_float_converter #(.SIGNED(1'b1)) u_dut_s (
    .clk_i(clk), .rst_i(rst_i), .operand_i(operand_i), .valid_i(valid_i),
    .ready_o(ready_s), .result_o(result_s), .inexact_o(inexact_s),
    .valid_o(valid_s), .ready_i(ready_i)
  );

  int_to_float_converter #(.SIGNED(1'b0)) u_dut_u (
    .clk_i(clk), .rst_i(rst_i), .operand_i(operand_i), .valid_i(valid_i),
    .ready_o(ready_u), .result_o(result_u), .inexact_o(inexact_u),
    .valid_o(valid_u), .ready_i(ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: exact magnitude, true binary exponent, then round the quotient to 24 bits.
  function automatic logic [32:0] model(input logic [31:0] op, input bit sgn);
    longint m, q, r, half;
    int e, sh;
    bit s;
    logic [7:0] ef;
    s = sgn && op[31];
    m = longint'({32'd0, op});
    if (s) m = 64'sd4294967296 - m;
    if (m == 0) return 33'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    r = 0;
    if (e <= 23) q = m << (23 - e);
    else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 64'sd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
    end
    if (q == (64'sd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    ef = 8'(e + 127);
    return {(r != 0), s, ef, q[22:0]};
  endfunction

  // One stimulus cycle; expectations are queued if the operand is really accepted.
  task automatic step(input bit v, input logic [31:0] op, input bit rdy, input bit dir,
                      input logic [32:0] es, input logic [32:0] eu, input bit lat);
    exp_t e;
    logic [32:0] ms, mu;
    valid_i   = v;
    operand_i = op;
    ready_i   = rdy;
    @(negedge clk);
    if (v && ready_s) begin
      ms = dir ? es : model(op, 1'b1);
      mu = dir ? eu : model(op, 1'b0);
      e.acc_cyc = cyc;
      e.lat     = lat;
      e.res = ms[31:0]; e.inx = ms[32]; q_s.push_back(e);
      e.res = mu[31:0]; e.inx = mu[32]; q_u.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, rdy, 1'b0, 33'd0, 33'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 4))
      0: x = x >> $urandom_range(0, 31);
      1: x = 32'hFFFF_FFFF << $urandom_range(0, 31);
      2: x = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 8));
      default: ;
    endcase
    return x;
  endfunction

  // Monitor: pops on every consumed result and watches stalls for stability.
  bit          prev_stall = 0;
  logic [31:0] prev_res;
  logic        prev_inx;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      prev_stall = 0;
    end else begin
      chk("valid_o signed/unsigned agree", 32'(valid_u), 32'(valid_s));
      if (prev_stall) begin
        chk("stall valid_o held", 32'(valid_s), 32'd1);
        chk("stall result_o held", result_s, prev_res);
        chk("stall inexact_o held", 32'(inexact_s), 32'(prev_inx));
      end
      if (valid_s && !ready_i) chk("ready_o low in stall", 32'(ready_s), 32'd0);
      if (valid_s && ready_i) begin
        if (q_s.size() == 0 || q_u.size() == 0) begin
          chk("unexpected result (queue empty)", result_s, 32'hDEAD_BEEF);
        end else begin
          e = q_s.pop_front();
          chk("result_o signed", result_s, e.res);
          chk("inexact_o signed", 32'(inexact_s), 32'(e.inx));
          if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd3);
          e = q_u.pop_front();
          chk("result_o unsigned", result_u, e.res);
          chk("inexact_o unsigned", 32'(inexact_u), 32'(e.inx));
        end
      end
      prev_stall = valid_s && !ready_i;
      prev_res   = result_s;
      prev_inx   = inexact_s;
    end
  end

  logic [31:0] d_op[8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
                           32'h7FFF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'h00FF_FFFF};
  logic [32:0] d_es[8] = '{{1'b0, 32'h3F80_0000}, {1'b0, 32'hBF80_0000}, {1'b0, 32'h0000_0000},
                           {1'b0, 32'hCF00_0000}, {1'b1, 32'h4F00_0000}, {1'b1, 32'h4B80_0000},
                           {1'b1, 32'h4B80_0002}, {1'b0, 32'h4B7F_FFFF}};
  logic [32:0] d_eu[8] = '{{1'b0, 32'h3F80_0000}, {1'b1, 32'h4F80_0000}, {1'b0, 32'h0000_0000},
                           {1'b0, 32'h4F00_0000}, {1'b1, 32'h4F00_0000}, {1'b1, 32'h4B80_0000},
                           {1'b1, 32'h4B80_0002}, {1'b0, 32'h4B7F_FFFF}};

  initial begin
    int  k;
    bit  seen;
    rst_i = 1'b1; valid_i = 1'b0; operand_i = 32'd0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid_o", 32'(valid_s), 32'd0);
    chk("reset result_o", result_s, 32'd0);
    chk("reset inexact_o", 32'(inexact_s), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_o after reset", 32'(ready_s), 32'd1);
    @(posedge clk); #1;

    // Directed back-to-back conversions with fixed latency
    for (int i = 0; i < 8; i++) step(1'b1, d_op[i], 1'b1, 1'b1, d_es[i], d_eu[i], 1'b1);
    idle(5, 1'b1);

    // Back-pressure: five operands, then four refused cycles with valid_i still high
    for (int i = 0; i < 5; i++) step(1'b1, rand_op(), 1'b1, 1'b0, 33'd0, 33'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rand_op(), 1'b0, 1'b0, 33'd0, 33'd0, 1'b0);
    idle(6, 1'b1);

    // Sparse arrivals with ready_i low until the first result shows up
    seen = 0;
    for (k = 0; k < 30 && !seen; k++) begin
      step(k % 3 == 0, rand_op(), 1'b0, 1'b0, 33'd0, 33'd0, 1'b0);
      seen = valid_s;
    end
    chk("bubble: result appeared", 32'(seen), 32'd1);
    step(1'b1, rand_op(), 1'b0, 1'b0, 33'd0, 33'd0, 1'b0);
    chk("bubble: ready_o low when full and stalled", 32'(ready_s), 32'd0);
    idle(6, 1'b1);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, rand_op(), $urandom_range(0, 9) < 6, 1'b0, 33'd0, 33'd0, 1'b0);
    idle(6, 1'b1);
    chk("queue drained before reset test", 32'(q_s.size()), 32'd0);

    // Reset with three conversions in flight
    for (int i = 0; i < 3; i++) step(1'b1, rand_op(), 1'b0, 1'b0, 33'd0, 33'd0, 1'b0);
    chk("three in flight then ready_o low", 32'(ready_s), 32'd0);
    rst_i = 1'b1;
    q_s.delete();
    q_u.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid reset valid_o", 32'(valid_s), 32'd0);
    chk("mid reset result_o", result_s, 32'd0);
    chk("mid reset inexact_o", 32'(inexact_s), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle(8, 1'b1);
    chk("no stale result after reset", 32'(valid_s), 32'd0);

    // Final short burst to confirm the pipe is healthy after reset
    for (int i = 0; i < 4; i++) step(1'b1, rand_op(), 1'b1, 1'b0, 33'd0, 33'd0, 1'b1);
    idle(5, 1'b1);
    chk("signed queue empty at end", 32'(q_s.size()), 32'd0);
    chk("unsigned queue empty at end", 32'(q_u.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
